alu_req_arbiter: RTL
====================

# alu_req_arbiter

Shares the single combinational ALU (ADD/SUB/AND/OR/XOR/SRA/SRL/NOR, 6-bit opcode) between two requesters, such as the switch/button front end and a scripted command source. Each request is accepted through a valid/ready handshake and its operands and opcode are registered. The block drives the ALU, captures the result and returns it through a per-requester response handshake. Grants alternate round-robin, and only one operation is in flight at a time.

## Interface
- NB_AB, 4, operand/result width
- NB_OP, 6, opcode width
- clock  in  1  single clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset (0 = reset)
- i_req_valid  in  2  request valid, bit g = requester g
- o_req_ready  out  2  request accepted this cycle (one-hot or zero)
- i_a0, i_b0  in  NB_AB each  requester 0 operands
- i_op0  in  NB_OP  requester 0 opcode
- i_a1, i_b1  in  NB_AB each  requester 1 operands
- i_op1  in  NB_OP  requester 1 opcode
- o_alu_a, o_alu_b  out  NB_AB each  registered ALU operands
- o_alu_op  out  NB_OP  registered ALU opcode
- i_alu_result  in  NB_AB  combinational ALU result
- o_rsp_valid  out  2  response valid, one-hot or zero
- i_rsp_ready  in  2  response consumed by requester g
- o_rsp_data  out  NB_AB  captured result
- o_rsp_err  out  1  illegal-opcode flag (see Configuration)
- o_busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - Grant selection: if exactly one i_req_valid bit is set, that requester is granted.
  - If both bits are set, the requester not granted last wins. The priority pointer resets to favour requester 0.
  - o_req_ready[g] is asserted combinationally for the granted requester only, and only in IDLE.
  - On handshake (valid & ready) at an edge: the granted requester's A, B and op are loaded into o_alu_a/b/op, g is latched, and the FSM goes to EXEC.
- EXEC (1 cycle):
  - The ALU settles on the registered inputs.
  - At the edge, i_alu_result is loaded into o_rsp_data and the FSM goes to RESP.
- RESP:
  - o_rsp_valid[g] = 1. o_rsp_data and o_rsp_err are held stable.
  - When i_rsp_ready[g] = 1 at an edge: o_rsp_valid clears, the pointer records g as last granted, and the FSM goes to IDLE.
  - i_rsp_ready of the other requester is ignored.
- o_alu_a/b/op hold their last value outside a load and do not toggle in IDLE.
- Requests arriving while busy see ready = 0. Requesters must hold valid and payload until accepted.
- Width: the result is exactly NB_AB bits as produced by the ALU. This block applies no extension or truncation.

## Timing
- Reset values: state IDLE, pointer = requester 0 preferred, all outputs 0 (o_req_ready 0 while i_reset = 0).
- Latency: handshake at edge N; o_rsp_valid rises after edge N+1; earliest response consumption at edge N+2; next accept at edge N+3 at the earliest.
- Maximum throughput: 1 operation per 3 cycles.
- Reset mid-operation (EXEC or RESP): the operation is abandoned with no response, and all outputs return to reset values on that edge.
- A requester dropping valid before it is accepted is legal. Dropping it after acceptance has no effect.

## Configuration
- ALU_OPCODE_CHECK_EN defined:
  - At the accept edge, the opcode is checked against {100000, 100010, 100100, 100101, 100110, 000011, 000010, 100111}.
  - Illegal opcode: o_alu_a/b/op are not updated, EXEC is skipped (IDLE → RESP directly), o_rsp_data = 0, o_rsp_err = 1.
  - Legal opcode: o_rsp_err = 0.
- ALU_OPCODE_CHECK_EN undefined: o_rsp_err is tied to 0, and every opcode is issued to the ALU unchanged.

## Test plan
- Single request: requester 0, A=0011, B=0100, op=100000, rsp_ready tied high → ready[0] pulses once; rsp_valid[0] appears 2 cycles after accept; data=0111; err=0.
- Contention:
  - Both valid at reset exit, req0 A=0101, B=0011, op SUB; req1 A=1100, B=1010, op AND.
  - Expected: req0 served first (data 0010), then req1 (data 1000).
  - Then both valid again: req0 wins (last granted was req1).
- Back-pressure: i_rsp_ready[1] low for 5 cycles after rsp_valid[1] rises, with a pending req0 → data and valid are stable for 5 cycles; ready[0] stays 0 and o_busy=1 until the consume edge.
- Shift op: A=1000, B=0001, op 000011 → data 1100; op 000010 → data 0100.
- Illegal opcode 111111:
  - With ALU_OPCODE_CHECK_EN: err=1, data=0000, o_alu_op unchanged, response 1 cycle after accept.
  - Without the macro: o_alu_op=111111 and err=0.
- Reset mid-EXEC: i_reset=0 for one edge during EXEC → no rsp_valid; all outputs 0; the next simultaneous request grants requester 0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
// Shares one external combinational ALU between two requesters. Each
// request is accepted with a valid/ready handshake. Its operands and opcode
// are registered onto the ALU inputs. The result is captured one cycle later
// and returned on a per-requester response handshake. Grants alternate
// round-robin, and only one operation is in flight at a time.
//
// Optional feature: define ALU_OPCODE_CHECK_EN to reject unknown opcodes.
// A rejected opcode is never issued to the ALU. It gets an immediate
// response with o_rsp_data = 0 and o_rsp_err = 1. When the macro is
// undefined, o_rsp_err is always 0.
//
// Ports
//   clock                 rising-edge clock
//   i_reset               synchronous reset, active low
//   i_req_valid/o_req_ready[1:0]   request handshake, bit g = requester g
//   i_a0/i_b0/i_op0       requester 0 payload
//   i_a1/i_b1/i_op1       requester 1 payload
//   o_alu_a/b/op          registered ALU inputs
//   i_alu_result          combinational ALU result
//   o_rsp_valid/i_rsp_ready[1:0]   response handshake
//   o_rsp_data, o_rsp_err captured result and illegal-opcode flag
//   o_busy                high while an operation is outstanding
module alu_req_arbiter #(
  parameter int NB_AB = 4,
  parameter int NB_OP = 6
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [NB_AB-1:0] i_a0,
  input  logic [NB_AB-1:0] i_b0,
  input  logic [NB_OP-1:0] i_op0,
  input  logic [NB_AB-1:0] i_a1,
  input  logic [NB_AB-1:0] i_b1,
  input  logic [NB_OP-1:0] i_op1,
  output logic [NB_AB-1:0] o_alu_a,
  output logic [NB_AB-1:0] o_alu_b,
  output logic [NB_OP-1:0] o_alu_op,
  input  logic [NB_AB-1:0] i_alu_result,
  output logic [1:0]       o_rsp_valid,
  input  logic [1:0]       i_rsp_ready,
  output logic [NB_AB-1:0] o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;    // requester owning the current operation
  logic             prio_q, prio_d;  // requester that wins a tie
  logic [NB_AB-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [NB_OP-1:0] alu_op_q, alu_op_d;
  logic [NB_AB-1:0] rsp_data_q, rsp_data_d;
  logic             err_q, err_d;

  logic             sel;
  logic [NB_AB-1:0] cur_a, cur_b;
  logic [NB_OP-1:0] cur_op;
  logic             op_legal;

  // Grant selection. Whenever any valid bit is set, sel points at a set bit.
  always_comb begin
    case (i_req_valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      default: sel = prio_q;
    endcase
    o_req_ready = 2'b00;
    if (state_q == IDLE && i_reset && (|i_req_valid)) o_req_ready[sel] = 1'b1;
    cur_a  = sel ? i_a1  : i_a0;
    cur_b  = sel ? i_b1  : i_b0;
    cur_op = sel ? i_op1 : i_op0;
  end

`ifdef ALU_OPCODE_CHECK_EN
  always_comb begin
    case (cur_op)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b000011, 6'b000010, 6'b100111: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  end
`else
  // Without the check, err_d is never set and err_q stays at 0.
  assign op_legal = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    prio_d     = prio_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (|o_req_ready) begin
        gnt_d = sel;
        if (op_legal) begin
          alu_a_d  = cur_a;
          alu_b_d  = cur_b;
          alu_op_d = cur_op;
          err_d    = 1'b0;
          state_d  = EXEC;
        end else begin
          // An illegal opcode never reaches the ALU, so EXEC is skipped.
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RESP;
        end
      end
      EXEC: begin
        rsp_data_d = i_alu_result;
        state_d    = RESP;
      end
      RESP: if (i_rsp_ready[gnt_q]) begin
        prio_d  = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      prio_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      prio_q     <= prio_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  assign o_alu_a     = alu_a_q;
  assign o_alu_b     = alu_b_q;
  assign o_alu_op    = alu_op_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = err_q;
  assign o_rsp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_busy      = (state_q != IDLE);

endmodule
